// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) memory arbiter, one transaction in flight.
// Round-robin grant on ties; read responses are routed back to the owner.
module mem_arbiter #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int RESP_BEATS = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ic_mem_req_valid,
  output logic                   ic_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
  input  logic                   ic_mem_req_rw,
  input  logic                   ic_mem_req_data_valid,
  output logic                   ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
  output logic                   ic_mem_resp_valid,
  output logic [DATA_BITS-1:0]   ic_mem_resp_data,

  input  logic                   dc_mem_req_valid,
  output logic                   dc_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic                   dc_mem_req_rw,
  input  logic                   dc_mem_req_data_valid,
  output logic                   dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
  output logic                   dc_mem_resp_valid,
  output logic [DATA_BITS-1:0]   dc_mem_resp_data,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int CW = (RESP_BEATS > 1) ? $clog2(RESP_BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(RESP_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          beat_q, beat_d;
  logic                   prefer_dc_q, prefer_dc_d;
  logic                   owner_dc_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   rw_q;
  logic [DATA_BITS-1:0]   data_q;
  logic [DATA_BITS/8-1:0] mask_q;

  logic ic_elig, dc_elig;
  logic grant_ic, grant_dc;
  logic accept;

  assign ic_elig  = ic_mem_req_valid &&
                    (!ic_mem_req_rw || ic_mem_req_data_valid);
  assign dc_elig  = dc_mem_req_valid &&
                    (!dc_mem_req_rw || dc_mem_req_data_valid);
  assign grant_dc = dc_elig && (!ic_elig || prefer_dc_q);
  assign grant_ic = ic_elig && !grant_dc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      prefer_dc_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      prefer_dc_q <= prefer_dc_d;
    end
  end

  // Request latches: the in-flight transaction never looks at clients again
  always_ff @(posedge clk) begin
    if (accept) begin
      owner_dc_q <= grant_dc;
      addr_q     <= grant_dc ? dc_mem_req_addr      : ic_mem_req_addr;
      rw_q       <= grant_dc ? dc_mem_req_rw        : ic_mem_req_rw;
      data_q     <= grant_dc ? dc_mem_req_data_bits : ic_mem_req_data_bits;
      mask_q     <= grant_dc ? dc_mem_req_data_mask : ic_mem_req_data_mask;
    end
  end

  always_comb begin
    state_d               = state_q;
    beat_d                = beat_q;
    prefer_dc_d           = prefer_dc_q;
    accept                = 1'b0;
    ic_mem_req_ready      = 1'b0;
    ic_mem_req_data_ready = 1'b0;
    dc_mem_req_ready      = 1'b0;
    dc_mem_req_data_ready = 1'b0;
    ic_mem_resp_valid     = 1'b0;
    dc_mem_resp_valid     = 1'b0;
    mem_req_valid         = 1'b0;
    mem_req_data_valid    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!reset) begin
          ic_mem_req_ready      = grant_ic;
          ic_mem_req_data_ready = grant_ic && ic_mem_req_rw;
          dc_mem_req_ready      = grant_dc;
          dc_mem_req_data_ready = grant_dc && dc_mem_req_rw;
          if (grant_ic || grant_dc) begin
            accept      = 1'b1;
            state_d     = ISSUE;
            prefer_dc_d = grant_ic;
          end
        end
      end
      ISSUE: begin
        mem_req_valid      = !reset;
        mem_req_data_valid = !reset && rw_q;
        if (mem_req_ready && (!rw_q || mem_req_data_ready)) begin
          state_d = rw_q ? IDLE : RESP;
          beat_d  = '0;
        end
      end
      RESP: begin
        if (mem_resp_valid) begin
          ic_mem_resp_valid = !reset && !owner_dc_q;
          dc_mem_resp_valid = !reset && owner_dc_q;
          if (beat_q == LAST) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_addr      = addr_q;
  assign mem_req_rw        = rw_q;
  assign mem_req_data_bits = data_q;
  assign mem_req_data_mask = mask_q;
  assign ic_mem_resp_data  = mem_resp_data;
  assign dc_mem_resp_data  = mem_resp_data;

endmodule
